adc_gray_ramp_ctrl: RTL and testbench

//   Sequences one single-slope column-ADC conversion: pulses ramp reset, waits a settle time,

---
 rtl/adc_ctrl_pkg.sv | 23 ++
 rtl/bin2gray.sv | 11 +
 rtl/adc_gray_ramp_ctrl.sv | 127 ++++++++++++
 tb/tb_adc_gray_ramp_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
// Shared column-ADC control types: FSM state encoding, registered control flags, default widths.
// Widths here are common to the column-latch and readout blocks that consume the gray bus.
package adc_ctrl_pkg;

  localparam int CNT_WIDTH_DEF    = 10;
  localparam int SETTLE_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RRST   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RAMP   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic busy;
    logic ramp_rst;
    logic ramp_en;
    logic done;
  } ctrl_flags_t;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-gray converter, zero latency; registering is left to the caller.
module bin2gray #(
  parameter int DATA_WIDTH = 10
) (
  input  logic [DATA_WIDTH-1:0] bin_i,
  output logic [DATA_WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/adc_gray_ramp_ctrl.sv
// Single-slope column-ADC conversion sequencer: ramp reset, settle, ramp with gray count, done.
// All outputs registered; gray bus lags the ramp counter by one cycle, so done_o meets the last code.
module adc_gray_ramp_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int SETTLE_WIDTH = SETTLE_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [CNT_WIDTH-1:0]    ramp_len_i,
  input  logic [SETTLE_WIDTH-1:0] settle_cycles_i,
  output logic                    busy_o,
  output logic                    ramp_rst_o,
  output logic                    ramp_en_o,
  output logic [CNT_WIDTH-1:0]    gray_cnt_o,
  output logic                    cnt_valid_o,
  output logic                    done_o
);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    ramp_len_q, ramp_len_d;
  logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
  logic [SETTLE_WIDTH-1:0] settle_cfg_q, settle_cfg_d;
  logic [CNT_WIDTH-1:0]    gray_q, gray_d;
  logic [CNT_WIDTH-1:0]    gray_next;
  logic                    cnt_valid_q, cnt_valid_d;
  ctrl_flags_t             flags_q, flags_d;

  bin2gray #(
    .DATA_WIDTH (CNT_WIDTH)
  ) u_bin2gray (
    .bin_i  (cnt_q),
    .gray_o (gray_next)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    ramp_len_d   = ramp_len_q;
    settle_cfg_d = settle_cfg_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          ramp_len_d   = ramp_len_i;
          settle_cfg_d = settle_cycles_i;
          state_d      = ST_RRST;
        end
      end
      ST_RRST: begin
        settle_d = '0;
        cnt_d    = '0;
        state_d  = (settle_cfg_q == '0) ? ST_RAMP : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == settle_cfg_q - SETTLE_WIDTH'(1)) begin
          state_d = ST_RAMP;
        end else begin
          settle_d = settle_q + SETTLE_WIDTH'(1);
        end
      end
      ST_RAMP: begin
        // Terminal compare before increment keeps an all-ones ramp_len from wrapping.
        if (cnt_q == ramp_len_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end

    cnt_valid_d = (state_q == ST_RAMP) && !abort_i;
    gray_d      = cnt_valid_d ? gray_next : '0;

    // Flags decode the next state so they line up with state_q in the following cycle.
    flags_d          = '0;
    flags_d.busy     = (state_d != ST_IDLE);
    flags_d.ramp_rst = (state_d == ST_RRST);
    flags_d.ramp_en  = (state_d == ST_RAMP);
    flags_d.done     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ramp_len_q   <= '0;
      settle_q     <= '0;
      settle_cfg_q <= '0;
      gray_q       <= '0;
      cnt_valid_q  <= 1'b0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ramp_len_q   <= ramp_len_d;
      settle_q     <= settle_d;
      settle_cfg_q <= settle_cfg_d;
      gray_q       <= gray_d;
      cnt_valid_q  <= cnt_valid_d;
      flags_q      <= flags_d;
    end
  end

  assign busy_o      = flags_q.busy;
  assign ramp_rst_o  = flags_q.ramp_rst;
  assign ramp_en_o   = flags_q.ramp_en;
  assign done_o      = flags_q.done;
  assign gray_cnt_o  = gray_q;
  assign cnt_valid_o = cnt_valid_q;

endmodule

// File: tb/tb_adc_gray_ramp_ctrl.sv
// Randomized bench for adc_gray_ramp_ctrl against a per-cycle timeline model of one conversion.
module tb_adc_gray_ramp_ctrl;

  localparam int CW = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic [CW-1:0] ramp_len_i;
  logic [SW-1:0] settle_cycles_i;
  logic          busy_o;
  logic          ramp_rst_o;
  logic          ramp_en_o;
  logic [CW-1:0] gray_cnt_o;
  logic          cnt_valid_o;
  logic          done_o;

  int n_checks = 0;
  int n_pass   = 0;

  adc_gray_ramp_ctrl #(
    .CNT_WIDTH    (CW),
    .SETTLE_WIDTH (SW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .ramp_len_i      (ramp_len_i),
    .settle_cycles_i (settle_cycles_i),
    .busy_o          (busy_o),
    .ramp_rst_o      (ramp_rst_o),
    .ramp_en_o       (ramp_en_o),
    .gray_cnt_o      (gray_cnt_o),
    .cnt_valid_o     (cnt_valid_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output vector {busy, ramp_rst, ramp_en, cnt_valid, done, gray}.
  function automatic logic [31:0] obs_vec();
    return 32'({busy_o, ramp_rst_o, ramp_en_o, cnt_valid_o, done_o, gray_cnt_o});
  endfunction

  // Cycle k counts from 1 = first cycle after the accepted start.
  // Timeline: 1 ramp-reset cycle, S settle cycles, L+1 ramp cycles, 1 done cycle;
  // gray codes trail the ramp by one cycle.
  function automatic logic [31:0] exp_vec(input int k, input int len, input int settle);
    int            last;
    int            b;
    logic          busy, rr, en, vld, dn;
    logic [CW-1:0] g;
    last = settle + len + 3;
    b    = k - settle - 3;
    busy = (k >= 1) && (k <= last);
    rr   = (k == 1);
    en   = (k >= settle + 2) && (k <= settle + 2 + len);
    vld  = (b >= 0) && (b <= len);
    dn   = (k == last);
    g    = vld ? CW'(b ^ (b >> 1)) : '0;
    return 32'({busy, rr, en, vld, dn, g});
  endfunction

  // Decode by exhaustive search over binary values rather than the XOR-prefix circuit.
  function automatic int gray_decode(input logic [CW-1:0] g);
    for (int b = 0; b < (1 << CW); b++) begin
      if (CW'(b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      start_i = 1'b0;
      abort_i = 1'($urandom_range(0, 1));
      step();
      check("idle_gap", obs_vec(), 32'd0);
    end
    abort_i = 1'b0;
  endtask

  // kill_at = 0 runs to completion; otherwise abort or reset is applied in cycle kill_at.
  task automatic run_conv(input int len, input int settle, input int kill_at, input bit kill_rst);
    int            last;
    int            busy_cnt;
    bit            have_prev;
    bit            killed;
    logic [CW-1:0] prev_g;
    last      = settle + len + 3;
    busy_cnt  = 0;
    have_prev = 1'b0;
    killed    = 1'b0;
    prev_g    = '0;
    ramp_len_i      = CW'(len);
    settle_cycles_i = SW'(settle);
    start_i         = 1'b1;
    abort_i         = 1'b0;
    step();
    for (int k = 1; k <= last + 1; k++) begin
      check($sformatf("cyc%0d_L%0d_S%0d", k, len, settle), obs_vec(), exp_vec(k, len, settle));
      if (busy_o) busy_cnt++;
      if (cnt_valid_o) begin
        if (have_prev) check("gray_one_bit", 32'($countones(gray_cnt_o ^ prev_g)), 32'd1);
        check("gray_decode", 32'(gray_decode(gray_cnt_o)), 32'(k - settle - 3));
        prev_g    = gray_cnt_o;
        have_prev = 1'b1;
      end
      if (k == last + 1) break;
      if (k == kill_at) begin
        killed = 1'b1;
        start_i = 1'($urandom_range(0, 1));
        if (kill_rst) begin
          rst = 1'b1;
          repeat (3) begin
            step();
            check("rst_hold", obs_vec(), 32'd0);
          end
          rst     = 1'b0;
          start_i = 1'b0;
          step();
          check("rst_release", obs_vec(), 32'd0);
        end else begin
          abort_i = 1'b1;
          step();
          check("abort_next", obs_vec(), 32'd0);
          abort_i = 1'b0;
          start_i = 1'b0;
        end
        break;
      end
      // Noise while busy must not disturb the running conversion.
      start_i         = (k == last) ? 1'b1 : 1'($urandom_range(0, 1));
      ramp_len_i      = CW'($urandom);
      settle_cycles_i = SW'($urandom);
      step();
    end
    start_i = 1'b0;
    if (!killed) check($sformatf("busy_len_L%0d_S%0d", len, settle), 32'(busy_cnt), 32'(last));
  endtask

  initial begin
    int len, settle, kill_at;
    bit kill_rst;
    rst             = 1'b1;
    start_i         = 1'b0;
    abort_i         = 1'b0;
    ramp_len_i      = '0;
    settle_cycles_i = '0;
    repeat (2) step();
    check("reset_state", obs_vec(), 32'd0);
    rst = 1'b0;
    step();
    check("idle_after_reset", obs_vec(), 32'd0);

    run_conv(5, 2, 0, 1'b0);
    run_conv(7, 0, 0, 1'b0);
    run_conv(0, 3, 0, 1'b0);
    run_conv(15, 1, 0, 1'b0);
    run_conv(0, 0, 0, 1'b0);
    run_conv(6, 3, 2, 1'b0);
    run_conv(8, 2, 7, 1'b0);
    run_conv(4, 1, 6, 1'b0);

    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    check("abort_start_idle", obs_vec(), 32'd0);
    start_i = 1'b0;
    abort_i = 1'b0;
    step();
    check("abort_start_idle_after", obs_vec(), 32'd0);

    run_conv(10, 1, 6, 1'b1);
    run_conv(3, 255, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      len      = $urandom_range(0, (1 << CW) - 1);
      settle   = $urandom_range(0, 10);
      kill_at  = 0;
      kill_rst = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        kill_at  = $urandom_range(1, settle + len + 3);
        kill_rst = ($urandom_range(0, 3) == 0);
      end
      run_conv(len, settle, kill_at, kill_rst);
      idle_gap($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
